// File: rtl/snake_body_move_if.sv
// Bundles the snake mover's key/grow inputs and its position/status outputs.
// slave is the snake mover itself; master is the surrounding game logic.
interface snake_body_move_if #(
  parameter int MAX_LEN = 16
);
  logic                   key_up;
  logic                   key_down;
  logic                   key_left;
  logic                   key_right;
  logic                   add_cube;
  logic [5:0]             head_x;
  logic [5:0]             head_y;
  logic [6*MAX_LEN-1:0]   body_x;
  logic [6*MAX_LEN-1:0]   body_y;
  logic [4:0]             body_len;
  logic                   step;
  logic                   game_over;

  modport master (
    output key_up, key_down, key_left, key_right, add_cube,
    input  head_x, head_y, body_x, body_y, body_len, step, game_over
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, add_cube,
    output head_x, head_y, body_x, body_y, body_len, step, game_over
  );
endinterface

// File: rtl/snake_body_move.sv
// Snake position/direction/length keeper: steps once per MOVE_DIV clocks,
// grows on apple requests and stops in DEAD on wall or self collision.
module snake_body_move #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int MOVE_DIV = 12_500_000,
  parameter int X_MAX    = 39,
  parameter int Y_MAX    = 29
) (
  input  logic             clk,
  input  logic             rst,
  snake_body_move_if.slave bus
);
  localparam int CW = $clog2(MOVE_DIV);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg;
  dir_t          dir_reg, commit_reg, req_dir, ref_dir;
  logic          req_valid, accept;
  logic          grow_pending_reg, grow_eff;
  logic [5:0]    seg_x_reg [MAX_LEN];
  logic [5:0]    seg_y_reg [MAX_LEN];
  logic [4:0]    body_len_reg, self_lim;
  logic [5:0]    next_x, next_y;
  logic          wall_hit, self_hit, collide;
  logic          tick, run, move;
  logic          step_reg;

  assign tick    = (cnt_reg == CW'(MOVE_DIV - 1));
  assign run     = (state_reg == RUN);
  assign collide = wall_hit | self_hit;
  assign move    = tick & run & ~collide;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_UP;
    if (bus.key_up) begin
      req_dir = DIR_UP;
    end else if (bus.key_down) begin
      req_dir = DIR_DOWN;
    end else if (bus.key_left) begin
      req_dir = DIR_LEFT;
    end else if (bus.key_right) begin
      req_dir = DIR_RIGHT;
    end else begin
      req_valid = 1'b0;
    end
  end

  // In the stepping cycle dir_reg is about to become the committed direction,
  // so a same-cycle request is checked against it to forbid a 180-degree turn.
  assign ref_dir = tick ? dir_reg : commit_reg;
  assign accept  = req_valid && (req_dir != dir_t'(ref_dir ^ 2'b01));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_reg    <= DIR_RIGHT;
      commit_reg <= DIR_RIGHT;
    end else begin
      if (accept) begin
        dir_reg <= req_dir;
      end
      if (move) begin
        commit_reg <= dir_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grow_pending_reg <= 1'b0;
    end else if (tick && run) begin
      grow_pending_reg <= 1'b0;
    end else if (bus.add_cube) begin
      grow_pending_reg <= 1'b1;
    end
  end

  assign grow_eff = (grow_pending_reg | bus.add_cube) && (body_len_reg < 5'(MAX_LEN));

  always_comb begin
    next_x = seg_x_reg[0];
    next_y = seg_y_reg[0];
    unique case (dir_reg)
      DIR_UP:    next_y = seg_y_reg[0] - 6'd1;
      DIR_DOWN:  next_y = seg_y_reg[0] + 6'd1;
      DIR_LEFT:  next_x = seg_x_reg[0] - 6'd1;
      DIR_RIGHT: next_x = seg_x_reg[0] + 6'd1;
    endcase
  end

  assign wall_hit = (next_x == 6'd0) || (next_x == 6'(X_MAX)) ||
                    (next_y == 6'd0) || (next_y == 6'(Y_MAX));

  // A growing snake keeps its tail, so the tail cell counts as occupied.
  always_comb begin
    self_lim = grow_eff ? body_len_reg : body_len_reg - 5'd1;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < self_lim) && (seg_x_reg[i] == next_x) && (seg_y_reg[i] == next_y)) begin
        self_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_reg[i] <= (i < INIT_LEN) ? 6'(20 - i) : 6'd0;
        seg_y_reg[i] <= (i < INIT_LEN) ? 6'd15 : 6'd0;
      end
    end else if (move) begin
      seg_x_reg[0] <= next_x;
      seg_y_reg[0] <= next_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_reg[i] <= seg_x_reg[i-1];
        seg_y_reg[i] <= seg_y_reg[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      body_len_reg <= 5'(INIT_LEN);
      step_reg     <= 1'b0;
    end else begin
      step_reg <= move;
      if (move && grow_eff) begin
        body_len_reg <= body_len_reg + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == RUN && tick && collide) begin
      state_next = DEAD;
    end
  end

  always_comb begin
    bus.game_over = (state_reg == DEAD);
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_pack
      assign bus.body_x[6*gi +: 6] = seg_x_reg[gi];
      assign bus.body_y[6*gi +: 6] = seg_y_reg[gi];
    end
  endgenerate

  assign bus.head_x   = seg_x_reg[0];
  assign bus.head_y   = seg_y_reg[0];
  assign bus.body_len = body_len_reg;
  assign bus.step     = step_reg;
endmodule

// File: doc/snake_body_move.md
Name: snake_body_move

Overview:
- Owns snake position, direction and length on the 40x30 cell playfield.
- Drives head_x/head_y into the apple/eat stage and consumes that stage's add_cube grow pulse.
- Exports the full segment list for the VGA renderer, plus a game_over flag.
- Steps the snake once per MOVE_DIV clocks and detects wall and self collisions.

Parameters:
- MAX_LEN, 16, maximum segment count including head.
- INIT_LEN, 3, segment count after reset (3..MAX_LEN).
- MOVE_DIV, 12_500_000, clock cycles per movement step (>=2).
- X_MAX, 39, wall column on the right; x=0 is the left wall.
- Y_MAX, 29, wall row at the bottom; y=0 is the top wall.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- key_up  in  1  direction request, already synchronised/debounced, level or pulse.
- key_down  in  1  direction request.
- key_left  in  1  direction request.
- key_right  in  1  direction request.
- add_cube  in  1  grow request from the apple stage, single-cycle pulse.
- head_x  out  6  current head column (= segment 0 x).
- head_y  out  6  current head row (= segment 0 y).
- body_x  out  6*MAX_LEN  segment x coords, segment i at bits [6i+5:6i].
- body_y  out  6*MAX_LEN  segment y coords, same packing.
- body_len  out  5  number of valid segments.
- step  out  1  one-cycle pulse in the cycle the snake moved.
- game_over  out  1  high while in DEAD.

Behaviour:
- Reset (async, rst low) values:
  - Segment i = (20-i, 15) for i < INIT_LEN; other segments = (0,0).
  - body_len = INIT_LEN; direction = RIGHT; grow_pending = 0.
  - Tick counter = 0; step = 0; game_over = 0; state = RUN.
- Tick counter: increments every clk and wraps at MOVE_DIV-1. step is asserted (registered) in the cycle after the wrap and only while in RUN. The counter keeps running in DEAD, but step stays 0.
- Direction register:
  - Sampled every cycle.
  - Priority when several keys are high: up > down > left > right.
  - A request for the reverse of the committed direction (the direction used at the last step) is ignored.
  - The latest accepted request before a step wins.
- Grow logic:
  - add_cube sets the sticky grow_pending flag.
  - grow = grow_pending | add_cube, evaluated in the stepping cycle.
  - On a step, grow_pending clears.
  - If grow and body_len < MAX_LEN, body_len increments and the old tail is retained.
  - At MAX_LEN, the request is consumed with no growth.
- Next head: current head moved by one cell in the committed direction. Arithmetic is 6-bit; collisions are checked before any wrap can occur.
- Collision check, on a step, in RUN:
  - Wall: next_x == 0 or next_x == X_MAX or next_y == 0 or next_y == Y_MAX.
  - Self: next head equals segment i for i in 0..body_len-2. If growing, the range is 0..body_len-1, because the tail does not vacate.
  - On any collision: state -> DEAD, all segments and body_len frozen, game_over = 1 from the next cycle.
- Normal step: seg[i] <= seg[i-1] for i = 1..MAX_LEN-1; seg[0] <= next head. Segments at index >= body_len are don't-care for rendering but must be deterministic.
- States:
  - RUN -> DEAD on collision.
  - DEAD is left only by rst.
- Latency: head_x/head_y update in the cycle after the counter wrap, together with step.

Test Plan:
- Reset, no keys, MOVE_DIV=4 -> head (20,15) → (21,15) → (22,15) on successive steps; body_len = 3; segment 2 follows at (19,15) then (20,15).
- key_left pulse while moving RIGHT -> ignored, head continues +x. key_up then one step -> head y decrements by 1.
- add_cube pulse mid-interval -> next step: body_len 3 → 4, tail unchanged. add_cube asserted in the stepping cycle itself also grows on that step.
- Run right from reset for 18 steps -> head reaches (38,15). The 19th step would reach x = 39 → game_over = 1, head stays (38,15), step stays 0 afterwards.
- With body_len 5, steer up, left, down -> head re-enters segment 3 → DEAD.
  - Same loop at body_len 4, moving into the vacating tail cell without growing → no collision.
- Issue 20 add_cube pulses -> body_len saturates at 16; further pulses are consumed with no change. Assert rst mid-run → immediate reset values.
